// File: rtl/maxunpool1d_stream_pkg.sv
// Shared defaults and width helpers for the CNN streaming stages.
// Optional build macro UNPOOL_REPEAT_EN is consumed by the unpool files, not here.
package maxunpool1d_stream_pkg;

   localparam int unsigned DefDataWidth = 8;
   localparam int unsigned DefChannels  = 32;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/maxunpool1d_stream_unpool_lane.sv
// One channel of the unpool stage: idx/phase compare with zero fill and range detect.
// UNPOOL_REPEAT_EN selects nearest-neighbour repeat (index ignored, never out of range).
module maxunpool1d_stream_unpool_lane
   import maxunpool1d_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned IDX_WIDTH  = 1,
   parameter int unsigned POOL_SIZE  = 2
) (
   input  logic [DATA_WIDTH-1:0] hold_val,
   input  logic [IDX_WIDTH-1:0]  hold_idx,
   input  logic [IDX_WIDTH-1:0]  phase,
   input  logic [IDX_WIDTH-1:0]  chk_idx,
   output logic [DATA_WIDTH-1:0] lane_out,
   output logic                  chk_oor
);

`ifdef UNPOOL_REPEAT_EN
   logic unused_idx;
   assign unused_idx = ^{hold_idx, phase, chk_idx};
   assign lane_out   = hold_val;
   assign chk_oor    = 1'b0;
`else
   localparam logic [IDX_WIDTH:0] POOL_LIM = (IDX_WIDTH+1)'(POOL_SIZE);

   // chk_idx is the incoming index, checked at acceptance time for the sticky error
   assign chk_oor  = ({1'b0, chk_idx} >= POOL_LIM);
   assign lane_out = (({1'b0, hold_idx} < POOL_LIM) && (hold_idx == phase)) ? hold_val : '0;
`endif

endmodule

// File: rtl/maxunpool1d_stream.sv
// Streaming 1-D max-unpool: one held input beat expands into POOL_SIZE output beats.
// Define UNPOOL_REPEAT_EN for nearest-neighbour upsampling instead of index-based unpool.
module maxunpool1d_stream
   import maxunpool1d_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned CHANNELS   = DefChannels,
   parameter int unsigned POOL_SIZE  = 2,
   parameter int unsigned IN_LENGTH  = 8,
   parameter int unsigned IDX_WIDTH  = clog2_min1(POOL_SIZE)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
   input  logic [CHANNELS*IDX_WIDTH-1:0]  in_idx,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic                           out_frame_last,
   output logic                           idx_err
);

   localparam int unsigned CNT_WIDTH = clog2_min1(IN_LENGTH);
   localparam logic [IDX_WIDTH-1:0] LAST_PHASE = IDX_WIDTH'(POOL_SIZE - 1);
   localparam logic [CNT_WIDTH-1:0] LAST_CNT   = CNT_WIDTH'(IN_LENGTH - 1);

   logic                           busy_q, busy_d;
   logic [IDX_WIDTH-1:0]           phase_q, phase_d;
   logic [CNT_WIDTH-1:0]           in_cnt_q, in_cnt_d;
   logic [CHANNELS*DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic [CHANNELS*IDX_WIDTH-1:0]  hold_idx_q, hold_idx_d;
   logic                           idx_err_q, idx_err_d;

   logic [CHANNELS*DATA_WIDTH-1:0] lane_data;
   logic [CHANNELS-1:0]            lane_oor;
   logic                           phase_last, load, xfer;

   assign phase_last = (phase_q == LAST_PHASE);
   // Accept on the final beat of an expansion so streaming has no bubbles
   assign in_ready   = !busy_q || (phase_last && out_ready);
   assign load       = in_valid && in_ready;
   assign xfer       = busy_q && out_ready;

   always_comb begin
      busy_d      = busy_q;
      phase_d     = phase_q;
      in_cnt_d    = in_cnt_q;
      hold_data_d = hold_data_q;
      hold_idx_d  = hold_idx_q;
      idx_err_d   = idx_err_q;
      if (xfer) begin
         if (phase_last) begin
            phase_d  = '0;
            busy_d   = 1'b0;
            in_cnt_d = (in_cnt_q == LAST_CNT) ? '0 : in_cnt_q + 1'b1;
         end else begin
            phase_d = phase_q + 1'b1;
         end
      end
      if (load) begin
         hold_data_d = in_data;
         hold_idx_d  = in_idx;
         busy_d      = 1'b1;
         phase_d     = '0;
         idx_err_d   = idx_err_q | (|lane_oor);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q      <= 1'b0;
         phase_q     <= '0;
         in_cnt_q    <= '0;
         hold_data_q <= '0;
         hold_idx_q  <= '0;
         idx_err_q   <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         phase_q     <= phase_d;
         in_cnt_q    <= in_cnt_d;
         hold_data_q <= hold_data_d;
         hold_idx_q  <= hold_idx_d;
         idx_err_q   <= idx_err_d;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      maxunpool1d_stream_unpool_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .IDX_WIDTH  (IDX_WIDTH),
         .POOL_SIZE  (POOL_SIZE)
      ) u_lane (
         .hold_val (hold_data_q[c*DATA_WIDTH +: DATA_WIDTH]),
         .hold_idx (hold_idx_q[c*IDX_WIDTH +: IDX_WIDTH]),
         .phase    (phase_q),
         .chk_idx  (in_idx[c*IDX_WIDTH +: IDX_WIDTH]),
         .lane_out (lane_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .chk_oor  (lane_oor[c])
      );
   end

   // Gate with busy so stale hold contents never appear on an idle bus
   assign out_data       = busy_q ? lane_data : '0;
   assign out_valid      = busy_q;
   assign out_last       = busy_q && phase_last;
   assign out_frame_last = out_last && (in_cnt_q == LAST_CNT);
   assign idx_err        = idx_err_q;

endmodule
